// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// seg7_pkg : glyph constants and scan-FSM state type for seg7_scan_driver
// Rev 1.0
// ============================================================================
package seg7_pkg;

  // Segment order is {g,f,e,d,c,b,a}, active high
  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_A     = 7'h77;
  localparam logic [6:0] GLYPH_B     = 7'h7C;
  localparam logic [6:0] GLYPH_C     = 7'h39;
  localparam logic [6:0] GLYPH_D     = 7'h5E;
  localparam logic [6:0] GLYPH_E     = 7'h79;
  localparam logic [6:0] GLYPH_F     = 7'h71;
  localparam logic [6:0] GLYPH_DASH  = 7'h40;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

endpackage
`default_nettype wire

// File: rtl/seg7_glyph_rom.sv
`default_nettype none
// ============================================================================
// seg7_glyph_rom : 4-bit digit code to 7-segment glyph (hex or decimal/dash)
// Rev 1.0
// ============================================================================
module seg7_glyph_rom
  import seg7_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       hex_mode_i,
  output logic [6:0] glyph_o
);

  always_comb begin
    glyph_o = GLYPH_BLANK;
    case (code_i)
      4'h0:    glyph_o = GLYPH_0;
      4'h1:    glyph_o = GLYPH_1;
      4'h2:    glyph_o = GLYPH_2;
      4'h3:    glyph_o = GLYPH_3;
      4'h4:    glyph_o = GLYPH_4;
      4'h5:    glyph_o = GLYPH_5;
      4'h6:    glyph_o = GLYPH_6;
      4'h7:    glyph_o = GLYPH_7;
      4'h8:    glyph_o = GLYPH_8;
      4'h9:    glyph_o = GLYPH_9;
      4'hA:    glyph_o = GLYPH_A;
      4'hB:    glyph_o = GLYPH_B;
      4'hC:    glyph_o = GLYPH_C;
      4'hD:    glyph_o = GLYPH_D;
      4'hE:    glyph_o = GLYPH_E;
      default: glyph_o = GLYPH_F;
    endcase
    if (!hex_mode_i && (code_i > 4'd9)) begin
      glyph_o = GLYPH_DASH;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// seg7_scan_driver : double-buffered, blank-interleaved N-digit 7-seg scanner
// Rev 1.0
// ============================================================================
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   en_in,
  input  logic                    load,
  input  logic                    hex_mode,
  input  logic                    lzb,
  output logic [NUM_DIGITS-1:0]   com,
  output logic [6:0]              seg,
  output logic                    seg_dp,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] SHOW_CNT = CNT_W'(BLANK_CYCLES - 1);

  logic [4*NUM_DIGITS-1:0] shadow_data_q, disp_data_q;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_en_q, disp_dp_q, disp_en_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  scan_state_e             state_q, state_d;
  logic [NUM_DIGITS-1:0]   com_q, com_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_done_q;

  logic                    slot_end, frame_end;
  logic [3:0]              disp_code [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   digit_zero, lead_zero;
  logic                    digit_blank;
  logic [6:0]              glyph;

  assign slot_end  = (cnt_q == LAST_CNT);
  assign frame_end = slot_end && (idx_q == LAST_IDX);

  always_comb begin
    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    assign disp_code[k]  = disp_data_q[4*k +: 4];
    assign digit_zero[k] = (disp_code[k] == 4'd0) || !disp_en_q[k];
  end

  // lead_zero[k]: digit k and every higher digit read as zero
  always_comb begin
    logic acc;
    acc       = 1'b1;
    lead_zero = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      acc          = acc & digit_zero[k];
      lead_zero[k] = acc;
    end
  end

  assign digit_blank = lzb && !hex_mode && (idx_q != '0) && lead_zero[idx_q];

  seg7_glyph_rom u_glyph_rom (
    .code_i     (disp_code[idx_q]),
    .hex_mode_i (hex_mode),
    .glyph_o    (glyph)
  );

  always_comb begin
    state_d = state_q;
    com_d   = '1;
    seg_d   = GLYPH_BLANK;
    dp_d    = 1'b0;
    case (state_q)
      BLANK: begin
        if (cnt_q == SHOW_CNT) state_d = SHOW;
      end
      SHOW: begin
        if (slot_end) state_d = BLANK;
        com_d[idx_q] = 1'b0;
        if (disp_en_q[idx_q]) begin
          seg_d = digit_blank ? GLYPH_BLANK : glyph;
          dp_d  = disp_dp_q[idx_q];
        end
      end
      default: state_d = BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      com_q        <= '1;
      seg_q        <= '0;
      dp_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      com_q        <= com_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_end;
    end
  end

  // A load landing on the frame boundary bypasses the shadow so it is not a frame late
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      shadow_en_q   <= '0;
      disp_data_q   <= '0;
      disp_dp_q     <= '0;
      disp_en_q     <= '0;
    end else begin
      if (load) begin
        shadow_data_q <= data_in;
        shadow_dp_q   <= dp_in;
        shadow_en_q   <= en_in;
      end
      if (frame_end) begin
        disp_data_q <= load ? data_in : shadow_data_q;
        disp_dp_q   <= load ? dp_in   : shadow_dp_q;
        disp_en_q   <= load ? en_in   : shadow_en_q;
      end
    end
  end

  assign com        = com_q;
  assign seg        = seg_q;
  assign seg_dp     = dp_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// tb_seg7_scan_driver : directed + random stimulus against a cycle-count reference model
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FRAME = SD * ND;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [15:0]   data_in;
  logic [3:0]    dp_in, en_in;
  logic          load, hex_mode, lzb;
  logic [3:0]    com;
  logic [6:0]    seg;
  logic          seg_dp, frame_done;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .en_in      (en_in),
    .load       (load),
    .hex_mode   (hex_mode),
    .lzb        (lzb),
    .com        (com),
    .seg        (seg),
    .seg_dp     (seg_dp),
    .frame_done (frame_done)
  );

  logic [6:0]  hex_tbl [16];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          m;
  logic [15:0] sh_data, ds_data;
  logic [3:0]  sh_dp, sh_en, ds_dp, ds_en;
  logic [3:0]  exp_com;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_fd;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s at edge %0d: observed %h expected %h", tag, m, obs, expv);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_com"},   16'(com),        16'hF);
    chk({tag, "_seg"},   16'(seg),        16'h0);
    chk({tag, "_dp"},    16'(seg_dp),     16'h0);
    chk({tag, "_frame"}, 16'(frame_done), 16'h0);
  endtask

  task automatic model_reset();
    m = 0;
    sh_data = '0; sh_dp = '0; sh_en = '0;
    ds_data = '0; ds_dp = '0; ds_en = '0;
  endtask

  // Expected outputs after the coming edge, from the m edges already taken
  task automatic predict();
    int cnt, k;
    bit blank;
    logic [3:0] code;
    cnt     = m % SD;
    k       = (m / SD) % ND;
    exp_com = 4'hF;
    exp_seg = 7'h00;
    exp_dp  = 1'b0;
    exp_fd  = ((m % FRAME) == FRAME - 1);
    if (cnt >= BC) begin
      exp_com[k] = 1'b0;
      if (ds_en[k]) begin
        code    = ds_data[4*k +: 4];
        exp_seg = (!hex_mode && code > 4'd9) ? 7'h40 : hex_tbl[code];
        blank   = lzb && !hex_mode && (k >= 1);
        for (int j = k; j < ND; j++) begin
          if (ds_data[4*j +: 4] != 4'd0 && ds_en[j]) blank = 1'b0;
        end
        if (blank) exp_seg = 7'h00;
        exp_dp = ds_dp[k];
      end
    end
  endtask

  task automatic step();
    predict();
    @(posedge clk);
    if ((m % FRAME) == FRAME - 1) begin
      ds_data = load ? data_in : sh_data;
      ds_dp   = load ? dp_in   : sh_dp;
      ds_en   = load ? en_in   : sh_en;
    end
    if (load) begin
      sh_data = data_in; sh_dp = dp_in; sh_en = en_in;
    end
    m++;
    #1;
    chk("com",        16'(com),        16'(exp_com));
    chk("seg",        16'(seg),        16'(exp_seg));
    chk("seg_dp",     16'(seg_dp),     16'(exp_dp));
    chk("frame_done", 16'(frame_done), 16'(exp_fd));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load_pulse(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
    data_in = d; dp_in = dp; en_in = en; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    hex_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    data_in = '0; dp_in = '0; en_in = '0; load = 1'b0; hex_mode = 1'b0; lzb = 1'b0;
    model_reset();

    #2 rst_n = 1'b0;
    #1 chk_reset("por_async");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_reset("por_held");
    end
    rst_n = 1'b1;

    // empty display: commons walk, segments dark, frame pulse every 32 clocks
    run(40);

    // mid-frame hex load must wait for the next frame
    hex_mode = 1'b1;
    load_pulse(16'h1A2F, 4'b0000, 4'b1111);
    run(70);

    // decimal mode: codes A and F become dashes
    hex_mode = 1'b0;
    run(40);

    // leading-zero blanking with a dp on a blanked digit
    lzb = 1'b1;
    load_pulse(16'h0050, 4'b0100, 4'b1111);
    run(70);

    // load exactly on the boundary edge: new data shown in the very next frame
    lzb = 1'b0;
    while ((m % FRAME) != FRAME - 1) step();
    load_pulse(16'h9999, 4'b0000, 4'b1111);
    run(40);

    // randomized loads, modes and enables
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) hex_mode = ~hex_mode;
      if ($urandom_range(0, 15) == 0) lzb = ~lzb;
      for (int d = 0; d < ND; d++) begin
        data_in[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        en_in[d]          = ($urandom_range(0, 4) != 0);
      end
      dp_in = 4'($urandom_range(0, 15));
      load  = ($urandom_range(0, 11) == 0);
      step();
      load = 1'b0;
    end

    // asynchronous reset in the middle of a SHOW slot
    while ((m % SD) != 4) step();
    #2 rst_n = 1'b0;
    #1 chk_reset("mid_async");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_reset("mid_held");
    end
    rst_n = 1'b1;
    model_reset();
    step();
    chk("restart_e1_com", 16'(com), 16'hF);
    step();
    chk("restart_e2_com", 16'(com), 16'hF);
    step();
    chk("restart_e3_com", 16'(com), 16'hE);
    chk("restart_e3_seg", 16'(seg), 16'h0);
    run(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
